cache_controller_nway: RTL and testbench

Parametrised N-way set-associative L1D controller. It owns its own tag, valid, dirty and LRU state, and sits between the CPU load/store request lines and the L2/write-buffer handshake. It is the successor to the fixed 2-way controller. New capabilities over that block:
- configurable associativity and address split
- true-LRU victim selection
- dirty write-back followed by allocate
- write-allocate on store miss

---
 rtl/cache_controller_nway.sv | 203 ++++++++++++++++++++
 tb/tb_cache_controller_nway.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller_nway.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller_nway
// Brief    : N-way set-associative L1D controller with true-LRU replacement,
//            dirty write-back and write-allocate on store miss.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller_nway #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5,
    parameter int INDEX_W  = 6,
    parameter int WAYS     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld,
    input  logic                     st,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     l2_ack,
    output logic                     hit,
    output logic                     miss,
    output logic                     load_ready,
    output logic                     write_l1,
    output logic                     read_l2,
    output logic                     write_l2,
    output logic [$clog2(WAYS)-1:0]  way_sel,
    output logic [ADDR_W-1:0]        l2_addr
);

    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int SETS   = 1 << INDEX_W;
    localparam int LINE_W = ADDR_W - OFFSET_W;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_compare   = 2'd1;
    localparam logic [1:0] c_st_writeback = 2'd2;
    localparam logic [1:0] c_st_allocate  = 2'd3;

    localparam logic [WAY_W-1:0] c_max_age = WAY_W'(WAYS - 1);

    logic [1:0]        r_state, w_next_state;
    logic [LINE_W-1:0] r_line;
    logic              r_is_ld;
    logic [WAY_W-1:0]  r_victim;

    logic [TAG_W-1:0]  r_tag_mem [SETS][WAYS];
    logic [WAYS-1:0]   r_valid   [SETS];
    logic [WAYS-1:0]   r_dirty   [SETS];
    logic [WAY_W-1:0]  r_age     [SETS][WAYS];

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [WAYS-1:0]    w_match;
    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic [WAY_W-1:0]   w_victim;
    logic               w_any_inv;
    logic               w_victim_dirty;
    logic               w_upd_en;
    logic [WAY_W-1:0]   w_upd_way;
    logic [WAY_W-1:0]   w_old_age;
    logic               w_unused_offset;

    // Only the line address is kept; the block offset never affects lookup.
    assign w_unused_offset = ^addr[OFFSET_W-1:0];
    assign w_tag = r_line[LINE_W-1:INDEX_W];
    assign w_idx = r_line[INDEX_W-1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way_match
        assign w_match[w] = r_valid[w_idx][w] && (r_tag_mem[w_idx][w] == w_tag);
    end

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_match[w]) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; with a full set the oldest way is evicted.
    always_comb begin
        w_victim  = '0;
        w_any_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_victim  = WAY_W'(w);
                w_any_inv = 1'b1;
            end
        end
        if (!w_any_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w_idx][w] == c_max_age) w_victim = WAY_W'(w);
            end
        end
    end

    assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];

    assign w_upd_en  = ((r_state == c_st_compare) && w_hit) ||
                       ((r_state == c_st_allocate) && l2_ack);
    assign w_upd_way = (r_state == c_st_compare) ? w_hit_way : r_victim;
    assign w_old_age = r_age[w_idx][w_upd_way];

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:      if (ld || st) w_next_state = c_st_compare;
            c_st_compare: begin
                if (w_hit)               w_next_state = c_st_idle;
                else if (w_victim_dirty) w_next_state = c_st_writeback;
                else                     w_next_state = c_st_allocate;
            end
            c_st_writeback: if (l2_ack) w_next_state = c_st_allocate;
            c_st_allocate:  if (l2_ack) w_next_state = c_st_compare;
            default:        w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        hit        = 1'b0;
        miss       = 1'b0;
        load_ready = 1'b0;
        write_l1   = 1'b0;
        read_l2    = 1'b0;
        write_l2   = 1'b0;
        way_sel    = '0;
        l2_addr    = '0;
        case (r_state)
            c_st_compare: begin
                hit        = w_hit;
                miss       = !w_hit;
                load_ready = w_hit && r_is_ld;
                write_l1   = w_hit && !r_is_ld;
                way_sel    = w_hit ? w_hit_way : w_victim;
            end
            c_st_writeback: begin
                write_l2 = 1'b1;
                way_sel  = r_victim;
                l2_addr  = {r_tag_mem[w_idx][r_victim], w_idx, {OFFSET_W{1'b0}}};
            end
            c_st_allocate: begin
                read_l2 = 1'b1;
                way_sel = r_victim;
                l2_addr = {w_tag, w_idx, {OFFSET_W{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line   <= '0;
            r_is_ld  <= 1'b0;
            r_victim <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
            end
        end else begin
            if ((r_state == c_st_idle) && (ld || st)) begin
                r_line  <= addr[ADDR_W-1:OFFSET_W];
                r_is_ld <= ld;
            end
            if ((r_state == c_st_compare) && !w_hit) r_victim <= w_victim;
            if ((r_state == c_st_compare) && w_hit && !r_is_ld)
                r_dirty[w_idx][w_hit_way] <= 1'b1;
            if ((r_state == c_st_writeback) && l2_ack)
                r_dirty[w_idx][r_victim] <= 1'b0;
            if ((r_state == c_st_allocate) && l2_ack) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
            end
            // True LRU: touched way becomes youngest, younger ways age by one.
            if (w_upd_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == w_upd_way)
                        r_age[w_idx][w] <= '0;
                    else if (r_age[w_idx][w] < w_old_age)
                        r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                end
            end
        end
    end

    // Tags are qualified by valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_st_allocate) && l2_ack)
            r_tag_mem[w_idx][r_victim] <= w_tag;
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_controller_nway
// Brief    : Directed self-checking bench for cache_controller_nway (WAYS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_controller_nway;

    logic        clk = 1'b0;
    logic        reset, ld, st, l2_ack;
    logic [31:0] addr;
    logic        hit, miss, load_ready, write_l1, read_l2, write_l2;
    logic [1:0]  way_sel;
    logic [31:0] l2_addr;
    logic [39:0] all_outs;

    int n_tests = 0;
    int n_fail  = 0;

    logic        obs_first_miss, obs_hit, obs_lr, obs_wl, obs_saw_wb, obs_saw_fill;
    int          obs_miss_cycles, obs_hit_cycle;
    logic [1:0]  obs_hit_way, obs_miss_way, obs_wb_way, obs_fill_way;
    logic [31:0] obs_wb_addr, obs_fill_addr;

    cache_controller_nway dut (
        .clk(clk), .reset(reset), .ld(ld), .st(st), .addr(addr), .l2_ack(l2_ack),
        .hit(hit), .miss(miss), .load_ready(load_ready), .write_l1(write_l1),
        .read_l2(read_l2), .write_l2(write_l2), .way_sel(way_sel), .l2_addr(l2_addr)
    );

    assign all_outs = {hit, miss, load_ready, write_l1, read_l2, write_l2, way_sel, l2_addr};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; ld = 1'b0; st = 1'b0; l2_ack = 1'b0; addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one request to completion, acking L2 after the given waits and
    // recording what the controller showed along the way.
    task automatic run_access(input logic [31:0] a, input logic l, input logic s,
                              input int wb_wait, input int fill_wait, input bit disturb);
        int wb_cnt, fill_cnt;
        bit done;
        wb_cnt = 0; fill_cnt = 0; done = 0;
        obs_first_miss = 0; obs_hit = 0; obs_lr = 0; obs_wl = 0; obs_saw_wb = 0;
        obs_saw_fill = 0; obs_miss_cycles = 0; obs_hit_cycle = 0; obs_hit_way = '0;
        obs_miss_way = '0; obs_wb_way = '0; obs_fill_way = '0; obs_wb_addr = '0;
        obs_fill_addr = '0;
        @(negedge clk);
        ld = l; st = s; addr = a;
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge clk);
            l2_ack = 1'b0;
            if (miss) begin
                obs_miss_cycles++;
                if (n == 1) obs_first_miss = 1'b1;
                obs_miss_way = way_sel;
            end
            if (hit) begin
                obs_hit = 1'b1; obs_hit_cycle = n; obs_lr = load_ready;
                obs_wl = write_l1; obs_hit_way = way_sel;
                ld = 1'b0; st = 1'b0; done = 1;
            end
            if (write_l2) begin
                obs_saw_wb = 1'b1; obs_wb_addr = l2_addr; obs_wb_way = way_sel;
                wb_cnt++;
                if (wb_cnt == wb_wait) l2_ack = 1'b1;
            end
            if (read_l2) begin
                obs_saw_fill = 1'b1; obs_fill_addr = l2_addr; obs_fill_way = way_sel;
                fill_cnt++;
                if (disturb && fill_cnt == 1) begin
                    addr = 32'h3000; st = ~st;
                end
                if (fill_cnt == fill_wait) l2_ack = 1'b1;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL access_timeout: addr %h got no hit within 200 cycles", a);
            ld = 1'b0; st = 1'b0; l2_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (all_outs !== 40'h0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs); end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (all_outs !== 40'h0) begin n_fail++; $display("FAIL idle_outs: got %h want 0", all_outs); end
    endtask

    task automatic test_miss_fill();
        run_access(32'h800, 1, 0, 0, 8, 0);
        n_tests++; if (obs_first_miss !== 1'b1) begin n_fail++; $display("FAIL t1_miss: got %b want 1", obs_first_miss); end
        n_tests++; if (obs_miss_cycles != 1) begin n_fail++; $display("FAIL t1_miss_cycles: got %0d want 1", obs_miss_cycles); end
        n_tests++; if (obs_fill_addr !== 32'h800) begin n_fail++; $display("FAIL t1_fill_addr: got %h want 800", obs_fill_addr); end
        n_tests++; if (obs_fill_way !== 2'd0) begin n_fail++; $display("FAIL t1_fill_way: got %0d want 0", obs_fill_way); end
        n_tests++; if (obs_saw_wb !== 1'b0) begin n_fail++; $display("FAIL t1_no_wb: got %b want 0", obs_saw_wb); end
        n_tests++; if ({obs_hit, obs_lr, obs_wl} !== 3'b110) begin n_fail++; $display("FAIL t1_hit_lr_wl: got %b want 110", {obs_hit, obs_lr, obs_wl}); end
        n_tests++; if (obs_hit_cycle != 10) begin n_fail++; $display("FAIL t1_latency: got %0d want 10", obs_hit_cycle); end
        @(negedge clk);
        n_tests++; if (all_outs !== 40'h0) begin n_fail++; $display("FAIL t1_back_idle: got %h want 0", all_outs); end
    endtask

    task automatic test_hit();
        run_access(32'h800, 1, 0, 0, 4, 0);
        n_tests++; if (obs_hit_cycle != 1) begin n_fail++; $display("FAIL t2_latency: got %0d want 1", obs_hit_cycle); end
        n_tests++; if (obs_saw_fill !== 1'b0) begin n_fail++; $display("FAIL t2_no_fill: got %b want 0", obs_saw_fill); end
        n_tests++; if ({obs_lr, obs_hit_way} !== 3'b100) begin n_fail++; $display("FAIL t2_lr_way: got %b want 100", {obs_lr, obs_hit_way}); end
    endtask

    task automatic test_clean_evict();
        logic [31:0] fills [3];
        fills[0] = 32'h1000; fills[1] = 32'h1800; fills[2] = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            run_access(fills[i], 1, 0, 0, 2, 0);
            n_tests++;
            if (obs_fill_way !== 2'(i + 1)) begin n_fail++; $display("FAIL t3_fill_way%0d: got %0d want %0d", i, obs_fill_way, i + 1); end
        end
        run_access(32'h800, 0, 1, 0, 2, 0);
        n_tests++; if ({obs_hit_cycle == 1, obs_wl, obs_lr, obs_hit_way} !== 5'b11000) begin n_fail++; $display("FAIL t3_st_hit: got %b want 11000", {obs_hit_cycle == 1, obs_wl, obs_lr, obs_hit_way}); end
        run_access(32'h1000, 1, 0, 0, 2, 0);
        n_tests++; if ({obs_hit_cycle == 1, obs_lr, obs_hit_way} !== 4'b1101) begin n_fail++; $display("FAIL t3_ld_hit: got %b want 1101", {obs_hit_cycle == 1, obs_lr, obs_hit_way}); end
        run_access(32'h2800, 1, 0, 0, 3, 0);
        n_tests++; if (obs_saw_wb !== 1'b0) begin n_fail++; $display("FAIL t3_no_wb: got %b want 0", obs_saw_wb); end
        n_tests++; if (obs_fill_addr !== 32'h2800) begin n_fail++; $display("FAIL t3_fill_addr: got %h want 2800", obs_fill_addr); end
        n_tests++; if ({obs_miss_way, obs_fill_way} !== 4'b1010) begin n_fail++; $display("FAIL t3_victim: got %b want 1010", {obs_miss_way, obs_fill_way}); end
        n_tests++; if (obs_lr !== 1'b1) begin n_fail++; $display("FAIL t3_lr: got %b want 1", obs_lr); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] fills [4];
        fills[0] = 32'h800; fills[1] = 32'h1000; fills[2] = 32'h1800; fills[3] = 32'h2000;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_access(fills[i], 0, 1, 0, 2, 0);
            n_tests++;
            if ({obs_first_miss, obs_wl, obs_lr, obs_hit_way} !== {3'b110, 2'(i)}) begin n_fail++; $display("FAIL t4_st_alloc%0d: got %b want %b", i, {obs_first_miss, obs_wl, obs_lr, obs_hit_way}, {3'b110, 2'(i)}); end
        end
        run_access(32'h2800, 1, 0, 3, 4, 0);
        n_tests++; if (obs_saw_wb !== 1'b1) begin n_fail++; $display("FAIL t4_wb_seen: got %b want 1", obs_saw_wb); end
        n_tests++; if (obs_wb_addr !== 32'h800) begin n_fail++; $display("FAIL t4_wb_addr: got %h want 800", obs_wb_addr); end
        n_tests++; if ({obs_wb_way, obs_fill_way} !== 4'b0000) begin n_fail++; $display("FAIL t4_ways: got %b want 0000", {obs_wb_way, obs_fill_way}); end
        n_tests++; if (obs_fill_addr !== 32'h2800) begin n_fail++; $display("FAIL t4_fill_addr: got %h want 2800", obs_fill_addr); end
        n_tests++; if (obs_lr !== 1'b1) begin n_fail++; $display("FAIL t4_lr: got %b want 1", obs_lr); end
        n_tests++; if (obs_hit_cycle != 9) begin n_fail++; $display("FAIL t4_latency: got %0d want 9", obs_hit_cycle); end
    endtask

    task automatic test_ld_st_priority();
        apply_reset();
        run_access(32'h800, 1, 0, 0, 2, 0);
        run_access(32'h800, 1, 1, 0, 2, 0);
        n_tests++; if ({obs_hit_cycle == 1, obs_lr, obs_wl} !== 3'b110) begin n_fail++; $display("FAIL t5_ld_prio: got %b want 110", {obs_hit_cycle == 1, obs_lr, obs_wl}); end
        @(negedge clk); l2_ack = 1'b1;
        @(negedge clk); l2_ack = 1'b0;
        n_tests++; if (all_outs !== 40'h0) begin n_fail++; $display("FAIL t5_stray_ack: got %h want 0", all_outs); end
        run_access(32'h1000, 1, 0, 0, 4, 1);
        n_tests++; if ({obs_fill_addr, obs_fill_way} !== {32'h1000, 2'd1}) begin n_fail++; $display("FAIL t5_ignore_req: got %h/%0d want 1000/1", obs_fill_addr, obs_fill_way); end
        n_tests++; if ({obs_lr, obs_wl} !== 2'b10) begin n_fail++; $display("FAIL t5_disturb_op: got %b want 10", {obs_lr, obs_wl}); end
        run_access(32'h1800, 1, 0, 0, 2, 0);
        run_access(32'h2000, 1, 0, 0, 2, 0);
        run_access(32'h2800, 1, 0, 2, 2, 0);
        n_tests++; if ({obs_saw_wb, obs_fill_way} !== 3'b000) begin n_fail++; $display("FAIL t5_clean_w0: got %b want 000", {obs_saw_wb, obs_fill_way}); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_access(32'h800, 1, 0, 0, 2, 0);
        @(negedge clk); ld = 1'b1; addr = 32'h1000;
        @(negedge clk);
        n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL t6_miss: got %b want 1", miss); end
        @(negedge clk);
        n_tests++; if (read_l2 !== 1'b1) begin n_fail++; $display("FAIL t6_in_alloc: got %b want 1", read_l2); end
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (all_outs !== 40'h0) begin n_fail++; $display("FAIL t6_abort: got %h want 0", all_outs); end
        reset = 1'b0; ld = 1'b0;
        @(negedge clk);
        n_tests++; if (all_outs !== 40'h0) begin n_fail++; $display("FAIL t6_idle: got %h want 0", all_outs); end
        run_access(32'h800, 1, 0, 0, 2, 0);
        n_tests++; if ({obs_first_miss, obs_lr} !== 2'b11) begin n_fail++; $display("FAIL t6_invalidated: got %b want 11", {obs_first_miss, obs_lr}); end
    endtask

    initial begin
        reset = 1'b1; ld = 1'b0; st = 1'b0; l2_ack = 1'b0; addr = '0;
        test_reset();
        test_miss_fill();
        test_hit();
        test_clean_evict();
        test_dirty_evict();
        test_ld_st_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
